// File: rtl/astra_pkg.sv
// -----------------------------------------------------------------------------
// astra_pkg
// Shared constants and helpers for the DAC output path.
//   DAC_W              : DAC data bus width
//   DAC_IDLE_CODE      : mid-scale code driven when the DAC is parked
//   DAC_DIV_DEFAULT    : default clk80 cycles per DAC sample
//   FIFO_DEPTH_DEFAULT : default sample buffer depth
//   UNDERRUN_CNT_W     : width of the saturating underrun counter
//   sat_inc_cnt()      : saturating increment for the underrun counter
// -----------------------------------------------------------------------------
package astra_pkg;

    localparam int DAC_W              = 8;
    localparam logic [DAC_W-1:0] DAC_IDLE_CODE = 8'h80;
    localparam int DAC_DIV_DEFAULT    = 8;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int UNDERRUN_CNT_W     = 16;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc_cnt(
        input logic [UNDERRUN_CNT_W-1:0] value
    );
        logic [UNDERRUN_CNT_W-1:0] result;
        if (value == {UNDERRUN_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + UNDERRUN_CNT_W'(1);
        end
        return result;
    endfunction

endpackage : astra_pkg

// File: rtl/dac_sample_pacer_if.sv
// -----------------------------------------------------------------------------
// dac_sample_pacer_if
// Valid/ready sample stream from the signal generator into the DAC pacer.
//   s_data  : 8-bit sample
//   s_valid : s_data holds a sample
//   s_ready : consumer accepts the sample this cycle
// Modports: master = sample producer, slave = pacer.
// -----------------------------------------------------------------------------
interface dac_sample_pacer_if;

    logic [astra_pkg::DAC_W-1:0] s_data;
    logic                        s_valid;
    logic                        s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface : dac_sample_pacer_if

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy output and first-word-fall-through read.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   push_i  : write data_i (ignored while full)
//   data_i  : write data
//   pop_i   : discard head entry (ignored while empty)
//   data_o  : current head entry (valid while empty_o = 0)
//   level_o : occupancy, 0..DEPTH
//   full_o  : level_o == DEPTH
//   empty_o : level_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == LW'(0));
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : sync_fifo

// File: rtl/dac_sample_pacer.sv
// -----------------------------------------------------------------------------
// dac_sample_pacer
// Buffers DAC samples and releases one every DIV clk80 cycles to a parallel
// DAC, generating a 50% duty strobe whose rising edge sits mid-sample.
//   clk80        : system clock
//   reset        : synchronous active-high reset
//   enable       : 1 = pace samples out, 0 = park at IDLE_CODE
//   s_if         : sample stream (slave side of dac_sample_pacer_if)
//   dac_db       : registered DAC data bus
//   dac_clk      : registered DAC strobe
//   fifo_level   : buffer occupancy
//   underrun     : one-cycle pulse when a sample tick finds the buffer empty
//   underrun_cnt : saturating underrun count
// -----------------------------------------------------------------------------
module dac_sample_pacer
    import astra_pkg::*;
#(
    parameter int               DIV        = DAC_DIV_DEFAULT,
    parameter int               FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [DAC_W-1:0] IDLE_CODE  = DAC_IDLE_CODE
) (
    input  logic                          clk80,
    input  logic                          reset,
    input  logic                          enable,
    dac_sample_pacer_if.slave             s_if,
    output logic [DAC_W-1:0]              dac_db,
    output logic                          dac_clk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_W-1:0]     underrun_cnt
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0]             cnt_q,      cnt_d;
    logic [DAC_W-1:0]          dac_db_q,   dac_db_d;
    logic                      dac_clk_q,  dac_clk_d;
    logic                      underrun_q, underrun_d;
    logic [UNDERRUN_CNT_W-1:0] ur_cnt_q,   ur_cnt_d;

    logic                      full_s;
    logic                      empty_s;
    logic [DAC_W-1:0]          head_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      tick_s;

    // Readiness comes from the pre-pop level, so a full buffer refuses a
    // push even in the cycle it is being popped.
    assign s_if.s_ready = ~reset & ~full_s;
    assign push_s       = s_if.s_valid & s_if.s_ready;
    assign tick_s       = enable & (cnt_q == CW'(0));
    assign pop_s        = tick_s & ~empty_s;

    sync_fifo #(
        .WIDTH (DAC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk80),
        .rst_i   (reset),
        .push_i  (push_s),
        .data_i  (s_if.s_data),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .level_o (fifo_level),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Divider, strobe, output data and underrun next-state.
    always_comb begin
        cnt_d      = cnt_q;
        dac_clk_d  = 1'b0;
        dac_db_d   = dac_db_q;
        underrun_d = 1'b0;
        ur_cnt_d   = ur_cnt_q;
        if (enable) begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = CW'(0);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            // Strobe lags the count by one register, so it stays low for the
            // first half of each sample period and rises mid-sample.
            dac_clk_d = (cnt_q >= CW'(DIV / 2));
            if (pop_s) begin
                dac_db_d = head_s;
            end else begin
                dac_db_d = dac_db_q;
            end
            underrun_d = tick_s & empty_s;
        end else begin
            cnt_d      = CW'(0);
            dac_clk_d  = 1'b0;
            dac_db_d   = IDLE_CODE;
            underrun_d = 1'b0;
        end
        if (underrun_d) begin
            ur_cnt_d = sat_inc_cnt(ur_cnt_q);
        end else begin
            ur_cnt_d = ur_cnt_q;
        end
    end

    // Output and divider registers.
    always_ff @(posedge clk80) begin
        if (reset) begin
            cnt_q      <= CW'(0);
            dac_clk_q  <= 1'b0;
            dac_db_q   <= IDLE_CODE;
            underrun_q <= 1'b0;
            ur_cnt_q   <= UNDERRUN_CNT_W'(0);
        end else begin
            cnt_q      <= cnt_d;
            dac_clk_q  <= dac_clk_d;
            dac_db_q   <= dac_db_d;
            underrun_q <= underrun_d;
            ur_cnt_q   <= ur_cnt_d;
        end
    end

    assign dac_db       = dac_db_q;
    assign dac_clk      = dac_clk_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ur_cnt_q;

endmodule : dac_sample_pacer

// File: tb/tb_dac_sample_pacer.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_pacer
// Self-checking bench for dac_sample_pacer (DIV = 8, FIFO_DEPTH = 16).
// The reference model keeps the buffer as a queue and the sample timing as
// "cycles spent enabled modulo DIV".
// -----------------------------------------------------------------------------
module tb_dac_sample_pacer;

    localparam int DIV   = 8;
    localparam int DEPTH = 16;

    logic        clk80 = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  dac_db;
    logic        dac_clk;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic [15:0] underrun_cnt;

    dac_sample_pacer_if s_if ();

    dac_sample_pacer #(
        .DIV        (DIV),
        .FIFO_DEPTH (DEPTH),
        .IDLE_CODE  (8'h80)
    ) dut (
        .clk80        (clk80),
        .reset        (reset),
        .enable       (enable),
        .s_if         (s_if),
        .dac_db       (dac_db),
        .dac_clk      (dac_clk),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk80 = ~clk80;

    // reference model state
    logic [7:0] q[$];
    int         phase;
    logic [7:0] m_db;
    logic       m_clk;
    logic       m_ur;
    int         m_ucnt;

    int total;
    int bad;

    // Advance one clock edge and update the model from the inputs present
    // at that edge; returns 1 ns after the edge.
    task automatic step();
        bit acc;
        @(posedge clk80);
        if (reset) begin
            q.delete();
            phase  = 0;
            m_db   = 8'h80;
            m_clk  = 1'b0;
            m_ur   = 1'b0;
            m_ucnt = 0;
        end else begin
            acc = s_if.s_valid && (q.size() != DEPTH);
            if (!enable) begin
                phase = 0;
                m_db  = 8'h80;
                m_clk = 1'b0;
                m_ur  = 1'b0;
            end else begin
                m_clk = ((phase % DIV) >= DIV / 2);
                m_ur  = 1'b0;
                if ((phase % DIV) == 0) begin
                    if (q.size() > 0) begin
                        m_db = q.pop_front();
                    end else begin
                        m_ur = 1'b1;
                        if (m_ucnt < 65535) m_ucnt++;
                    end
                end
                phase++;
            end
            if (acc) q.push_back(s_if.s_data);
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; s_if.s_valid = 1'b0; s_if.s_data = 8'h00;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; s_if.s_valid = 1'b0; s_if.s_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (dac_db !== 8'h80) begin bad++; $display("FAIL reset_db: got %h want 80", dac_db); end
            total++; if (dac_clk !== 1'b0) begin bad++; $display("FAIL reset_clk: got %b want 0", dac_clk); end
            total++; if (s_if.s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", s_if.s_ready); end
            total++; if (fifo_level !== 5'd0 || underrun_cnt !== 16'd0 || underrun !== 1'b0) begin
                bad++; $display("FAIL reset_state: level %0d ucnt %0d ur %b want 0", fifo_level, underrun_cnt, underrun);
            end
        end
        reset = 1'b0;
        #1;
        total++; if (s_if.s_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", s_if.s_ready); end
        step();
        total++; if (dac_db !== 8'h80 || dac_clk !== 1'b0) begin
            bad++; $display("FAIL idle_out: db %h clk %b want 80 0", dac_db, dac_clk);
        end
    endtask

    task automatic test_single();
        int t_chg = -1;
        int rises[$];
        logic prev_clk;
        apply_reset();
        enable = 1'b1; s_if.s_data = 8'h3C; s_if.s_valid = 1'b1;
        step();
        s_if.s_valid = 1'b0;
        prev_clk = dac_clk;
        for (int c = 0; c < 30; c++) begin
            step();
            total++; if (dac_db !== m_db) begin bad++; $display("FAIL single_db: cyc %0d got %h want %h", c, dac_db, m_db); end
            if (t_chg < 0 && dac_db === 8'h3C) t_chg = c;
            if (prev_clk === 1'b0 && dac_clk === 1'b1 && t_chg >= 0) rises.push_back(c);
            prev_clk = dac_clk;
        end
        total++;
        if (t_chg < 0 || rises.size() < 2) begin
            bad++; $display("FAIL single_strobe: change %0d rises %0d want change and 2 rises", t_chg, rises.size());
        end else begin
            if (rises[0] - t_chg != DIV / 2) begin bad++; $display("FAIL single_rise: got %0d want %0d", rises[0] - t_chg, DIV / 2); end
            total++;
            if (rises[1] - rises[0] != DIV) begin bad++; $display("FAIL single_period: got %0d want %0d", rises[1] - rises[0], DIV); end
        end
        enable = 1'b0;
    endtask

    task automatic test_burst();
        int acc = 0;
        logic [7:0] outs[$];
        int chg_t[$];
        logic [7:0] prev_db;
        logic [7:0] nxt;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            s_if.s_data = 8'(i); s_if.s_valid = 1'b1;
            #1;
            if (s_if.s_ready === 1'b1) acc++;
            step();
        end
        total++; if (acc != 16) begin bad++; $display("FAIL burst_accepted: got %0d want 16", acc); end
        total++; if (s_if.s_ready !== 1'b0 || fifo_level !== 5'd16) begin
            bad++; $display("FAIL burst_full: ready %b level %0d want 0 16", s_if.s_ready, fifo_level);
        end
        enable = 1'b1;
        nxt = 8'h10; s_if.s_data = nxt; s_if.s_valid = 1'b1;
        prev_db = dac_db;
        for (int c = 0; c < 180; c++) begin
            bit took;
            took = (s_if.s_valid === 1'b1) && (s_if.s_ready === 1'b1);
            step();
            if (took) begin
                nxt = nxt + 8'd1;
                s_if.s_data = nxt;
                if (nxt > 8'h13) s_if.s_valid = 1'b0;
            end
            total++; if (dac_db !== m_db) begin bad++; $display("FAIL burst_db: cyc %0d got %h want %h", c, dac_db, m_db); end
            if (dac_db !== prev_db) begin outs.push_back(dac_db); chg_t.push_back(c); end
            prev_db = dac_db;
        end
        total++;
        if (outs.size() != 20) begin
            bad++; $display("FAIL burst_count: got %0d outputs want 20", outs.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                total++; if (outs[i] !== 8'(i)) begin bad++; $display("FAIL burst_order: idx %0d got %h want %h", i, outs[i], 8'(i)); end
            end
            for (int i = 1; i < 20; i++) begin
                total++; if (chg_t[i] - chg_t[i-1] != DIV) begin bad++; $display("FAIL burst_spacing: idx %0d got %0d want %0d", i, chg_t[i] - chg_t[i-1], DIV); end
            end
        end
        s_if.s_valid = 1'b0; enable = 1'b0;
    endtask

    task automatic test_underrun();
        logic [7:0] s1;
        int pulses = 0;
        apply_reset();
        s_if.s_valid = 1'b1;
        s_if.s_data = 8'($urandom_range(0, 255)); step();
        s1 = 8'($urandom_range(0, 127));
        s_if.s_data = s1; step();
        s_if.s_valid = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 33; c++) begin
            step();
            if (underrun === 1'b1) pulses++;
            total++; if (underrun !== m_ur || dac_db !== m_db) begin
                bad++; $display("FAIL underrun_trace: cyc %0d ur %b db %h want %b %h", c, underrun, dac_db, m_ur, m_db);
            end
        end
        total++; if (underrun_cnt !== 16'd3) begin bad++; $display("FAIL underrun_cnt: got %0d want 3", underrun_cnt); end
        total++; if (pulses != 3) begin bad++; $display("FAIL underrun_pulses: got %0d want 3", pulses); end
        total++; if (dac_db !== s1) begin bad++; $display("FAIL underrun_hold: got %h want %h", dac_db, s1); end
        enable = 1'b0;
    endtask

    task automatic test_full_pop();
        apply_reset();
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_if.s_data = 8'($urandom_range(0, 255));
            step();
        end
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL fullpop_fill: got %0d want 16", fifo_level); end
        s_if.s_data = 8'hA5;
        enable = 1'b1;
        step();
        total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL fullpop_refused: got %0d want 15", fifo_level); end
        step();
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL fullpop_accept: got %0d want 16", fifo_level); end
        s_if.s_valid = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        apply_reset();
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.s_data = 8'($urandom_range(0, 255));
            step();
        end
        s_if.s_valid = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (dac_clk === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL midreset_strobe: got no strobe high within 20 cycles want high");
        end else begin
            reset = 1'b1;
            step();
            total++; if (dac_clk !== 1'b0 || dac_db !== 8'h80) begin
                bad++; $display("FAIL midreset_out: clk %b db %h want 0 80", dac_clk, dac_db);
            end
            total++; if (fifo_level !== 5'd0 || underrun_cnt !== 16'd0) begin
                bad++; $display("FAIL midreset_state: level %0d ucnt %0d want 0 0", fifo_level, underrun_cnt);
            end
        end
        reset = 1'b0; enable = 1'b0;
    endtask

    task automatic test_random();
        int rate;
        apply_reset();
        for (int c = 0; c < 1200; c++) begin
            if (c % 200 == 0) rate = $urandom_range(5, 100);
            reset        = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            s_if.s_valid = ($urandom_range(0, 99) < rate);
            s_if.s_data  = 8'($urandom_range(0, 255));
            #1;
            total++;
            if (s_if.s_ready !== (!reset && q.size() != DEPTH)) begin
                bad++; $display("FAIL rand_ready: cyc %0d got %b want %b", c, s_if.s_ready, (!reset && q.size() != DEPTH));
            end
            step();
            total++;
            if (dac_db !== m_db || dac_clk !== m_clk || underrun !== m_ur ||
                fifo_level !== 5'(q.size()) || underrun_cnt !== 16'(m_ucnt)) begin
                bad++;
                $display("FAIL rand_out: cyc %0d got db %h clk %b ur %b lvl %0d ucnt %0d want %h %b %b %0d %0d",
                         c, dac_db, dac_clk, underrun, fifo_level, underrun_cnt,
                         m_db, m_clk, m_ur, q.size(), m_ucnt);
            end
        end
        reset = 1'b0; enable = 1'b0; s_if.s_valid = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        phase  = 0;
        m_db   = 8'h80;
        m_clk  = 1'b0;
        m_ur   = 1'b0;
        m_ucnt = 0;
        reset  = 1'b1;
        enable = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_underrun();
        test_full_pop();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dac_sample_pacer
